// File: rtl/dram_ctrl_pkg.sv
// Shared definitions for the DRAM controller front end.
// Holds the default geometry, derived field widths, the flat-address field
// offsets, the default-geometry request entry layout and the controller
// command encodings.
package dram_ctrl_pkg;

  // Default geometry
  localparam int unsigned DEF_NUMBER_OF_BANKS = 8;
  localparam int unsigned DEF_NUMBER_OF_ROWS  = 128;
  localparam int unsigned DEF_NUMBER_OF_COLS  = 8;
  localparam int unsigned DEF_FIFO_DEPTH      = 4;

  // Derived widths for the default geometry
  localparam int unsigned BANK_W = $clog2(DEF_NUMBER_OF_BANKS);
  localparam int unsigned ROW_W  = $clog2(DEF_NUMBER_OF_ROWS);
  localparam int unsigned COL_W  = $clog2(DEF_NUMBER_OF_COLS);
  localparam int unsigned ADDR_W = BANK_W + ROW_W + COL_W;

  // Flat address field offsets
  localparam int unsigned COL_LSB  = 0;
  localparam int unsigned ROW_LSB  = COL_W;
  localparam int unsigned BANK_LSB = COL_W + ROW_W;

  // Request entry for the default geometry
  typedef struct packed {
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic              we;
  } dram_req_t;

  // Controller command encodings
  typedef enum logic [1:0] {
    CMD_ACT  = 2'b00,
    CMD_RDWR = 2'b01,
    CMD_REF  = 2'b10,
    CMD_PRE  = 2'b11
  } dram_cmd_e;

endpackage

// File: rtl/dram_req_fifo.sv
// Generic synchronous FIFO with occupancy count and a head+1 peek port.
// Ports:
//   clk, rst_b       clock, asynchronous active-low reset
//   push_i, wdata_i  write request and data (ignored when full)
//   pop_i            read request (ignored when empty)
//   head_o, next_o   entry at read pointer and the one after it
//   count_o          stored entries
//   full_o, empty_o  occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module dram_req_fifo #(
  parameter int unsigned WIDTH = 14,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_o,
  output logic [WIDTH-1:0]             next_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign next_o  = mem_q[rd_ptr_q + PTR_W'(1)];

  // Pointer and occupancy next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/dram_req_queue.sv
// Request buffer in front of the DRAM controller FSM. Host requests are
// split into bank/row/col at push time, queued, and the head entry is held
// on the outputs until the FSM signals col_done.
// Ports:
//   clk, rst_b                     clock, asynchronous active-low reset
//   host_valid/host_ready          host handshake; host_addr, host_we payload
//   col_done                       FSM column access done, pops the head
//   addr_val, bank_id, row_id,
//   col_id, req_we                 head entry
//   fill_level                     stored entries
//   next_row_hit                   head+1 targets the same bank/row as head
//   pop_err                        sticky: col_done seen while empty
// Optional feature: define DRAM_REQ_LOOKAHEAD_EN to enable next_row_hit;
// otherwise it is tied to 0.
module dram_req_queue
  import dram_ctrl_pkg::*;
#(
  parameter int unsigned NUMBER_OF_BANKS = DEF_NUMBER_OF_BANKS,
  parameter int unsigned NUMBER_OF_ROWS  = DEF_NUMBER_OF_ROWS,
  parameter int unsigned NUMBER_OF_COLS  = DEF_NUMBER_OF_COLS,
  parameter int unsigned FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
  input  logic                                                   clk,
  input  logic                                                   rst_b,
  input  logic                                                   host_valid,
  output logic                                                   host_ready,
  input  logic [$clog2(NUMBER_OF_BANKS)+$clog2(NUMBER_OF_ROWS)
                +$clog2(NUMBER_OF_COLS)-1:0]                     host_addr,
  input  logic                                                   host_we,
  input  logic                                                   col_done,
  output logic                                                   addr_val,
  output logic [$clog2(NUMBER_OF_BANKS)-1:0]                     bank_id,
  output logic [$clog2(NUMBER_OF_ROWS)-1:0]                      row_id,
  output logic [$clog2(NUMBER_OF_COLS)-1:0]                      col_id,
  output logic                                                   req_we,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]                        fill_level,
  output logic                                                   next_row_hit,
  output logic                                                   pop_err
);

  localparam int unsigned Q_BANK_W  = $clog2(NUMBER_OF_BANKS);
  localparam int unsigned Q_ROW_W   = $clog2(NUMBER_OF_ROWS);
  localparam int unsigned Q_COL_W   = $clog2(NUMBER_OF_COLS);
  localparam int unsigned Q_ADDR_W  = Q_BANK_W + Q_ROW_W + Q_COL_W;
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENTRY_W   = Q_BANK_W + Q_ROW_W + Q_COL_W + 1;

  typedef struct packed {
    logic [Q_BANK_W-1:0] bank;
    logic [Q_ROW_W-1:0]  row;
    logic [Q_COL_W-1:0]  col;
    logic                we;
  } entry_t;

  entry_t           wr_entry, head_entry, next_entry;
  logic [CNT_W-1:0] count;
  logic             full, empty, push, pop;
  logic             pop_err_q, pop_err_d;

  // Split the flat address once, at push time
  always_comb begin
    wr_entry.col  = host_addr[Q_COL_W-1:0];
    wr_entry.row  = host_addr[Q_COL_W+Q_ROW_W-1:Q_COL_W];
    wr_entry.bank = host_addr[Q_ADDR_W-1:Q_COL_W+Q_ROW_W];
    wr_entry.we   = host_we;
  end

  // host_ready comes from occupancy only, so a pop cannot make room same-cycle
  assign host_ready = ~full;
  assign push       = host_valid & host_ready;
  assign pop        = col_done & ~empty;

  dram_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_b   (rst_b),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .head_o  (head_entry),
    .next_o  (next_entry),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign addr_val   = ~empty;
  assign bank_id    = head_entry.bank;
  assign row_id     = head_entry.row;
  assign col_id     = head_entry.col;
  assign req_we     = head_entry.we;
  assign fill_level = count;

  // Sticky underflow flag
  always_comb begin
    pop_err_d = pop_err_q | (col_done & empty);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) pop_err_q <= 1'b0;
    else        pop_err_q <= pop_err_d;
  end

  assign pop_err = pop_err_q;

`ifdef DRAM_REQ_LOOKAHEAD_EN
  // Same bank and row behind the head lets the FSM skip a precharge
  logic unused_peek;
  assign unused_peek  = ^{next_entry.col, next_entry.we};
  assign next_row_hit = (count >= CNT_W'(2)) &
                        (next_entry.bank == head_entry.bank) &
                        (next_entry.row == head_entry.row);
`else
  logic unused_peek;
  assign unused_peek  = ^next_entry;
  assign next_row_hit = 1'b0;
`endif

endmodule

// File: tb/tb_dram_req_queue.sv
module tb_dram_req_queue;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        host_valid;
  logic        host_ready;
  logic [12:0] host_addr;
  logic        host_we;
  logic        col_done;
  logic        addr_val;
  logic [2:0]  bank_id;
  logic [6:0]  row_id;
  logic [2:0]  col_id;
  logic        req_we;
  logic [2:0]  fill_level;
  logic        next_row_hit;
  logic        pop_err;

  typedef struct {
    logic [2:0] bank;
    logic [6:0] row;
    logic [2:0] col;
    logic       we;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   mcount   = 0;
  logic exp_hit;

  always #5 clk = ~clk;

  dram_req_queue dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .host_valid   (host_valid),
    .host_ready   (host_ready),
    .host_addr    (host_addr),
    .host_we      (host_we),
    .col_done     (col_done),
    .addr_val     (addr_val),
    .bank_id      (bank_id),
    .row_id       (row_id),
    .col_id       (col_id),
    .req_we       (req_we),
    .fill_level   (fill_level),
    .next_row_hit (next_row_hit),
    .pop_err      (pop_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: whenever the DUT pops its head, compare against the scoreboard
  always @(negedge clk) begin
    if (rst_b && addr_val && col_done) begin
      if (sb.size() == 0) begin
        check("pop_without_expected", 32'(addr_val), 32'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("head_bank", 32'(bank_id), 32'(e.bank));
        check("head_row",  32'(row_id),  32'(e.row));
        check("head_col",  32'(col_id),  32'(e.col));
        check("head_we",   32'(req_we),  32'(e.we));
      end
    end
  end

  // One cycle of stimulus; expected entries use the documented field layout
  task automatic step(input logic v, input logic [12:0] a, input logic we, input logic cd);
    bit   acc, rem;
    exp_t e;
    host_valid = v;
    host_addr  = a;
    host_we    = we;
    col_done   = cd;
    acc = v && (mcount != 4);
    rem = cd && (mcount != 0);
    if (acc) begin
      e.col  = a[2:0];
      e.row  = a[9:3];
      e.bank = a[12:10];
      e.we   = we;
      sb.push_back(e);
    end
    @(posedge clk);
    mcount = mcount + (acc ? 1 : 0) - (rem ? 1 : 0);
    #1;
    host_valid = 1'b0;
    col_done   = 1'b0;
  endtask

  initial begin
    rst_b = 1'b0; host_valid = 1'b0; host_addr = '0; host_we = 1'b0; col_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr_val", 32'(addr_val), 0);
    check("rst_fill",     32'(fill_level), 0);
    check("rst_pop_err",  32'(pop_err), 0);
    check("rst_hit",      32'(next_row_hit), 0);
    rst_b = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 32'(host_ready), 1);

    // Single request: 13'h1A5B -> bank 6, row 75, col 3
    step(1'b1, 13'h1A5B, 1'b1, 1'b0);
    check("single_val",  32'(addr_val), 1);
    check("single_bank", 32'(bank_id), 6);
    check("single_row",  32'(row_id), 75);
    check("single_col",  32'(col_id), 3);
    check("single_we",   32'(req_we), 1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("single_popped", 32'(addr_val), 0);

    // Fill to full; 5th request is held off
    step(1'b1, 13'h0011, 1'b0, 1'b0);
    step(1'b1, 13'h0422, 1'b1, 1'b0);
    step(1'b1, 13'h0833, 1'b0, 1'b0);
    step(1'b1, 13'h1C44, 1'b1, 1'b0);
    check("full_fill",  32'(fill_level), 4);
    check("full_ready", 32'(host_ready), 0);
    step(1'b1, 13'h1555, 1'b0, 1'b0);
    check("full_hold_fill", 32'(fill_level), 4);
    step(1'b1, 13'h1555, 1'b0, 1'b1);
    check("full_pop_fill",  32'(fill_level), 3);
    check("full_pop_ready", 32'(host_ready), 1);
    step(1'b1, 13'h1555, 1'b0, 1'b0);
    check("fifth_accepted", 32'(fill_level), 4);

    // Drain to 2, then simultaneous push/pop across pointer wrap
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("drain_fill", 32'(fill_level), 2);
    step(1'b1, 13'h0A66, 1'b1, 1'b1);
    check("pp_fill", 32'(fill_level), 2);
    check("pp_head_bank", 32'(bank_id), 5);
    step(1'b1, 13'h1177, 1'b0, 1'b1);
    step(1'b1, 13'h1988, 1'b1, 1'b1);
    step(1'b1, 13'h0299, 1'b0, 1'b1);
    check("pp_fill_after_wrap", 32'(fill_level), 2);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("drained_val",  32'(addr_val), 0);
    check("drained_fill", 32'(fill_level), 0);
    check("no_pop_err_yet", 32'(pop_err), 0);

    // Underflow
    step(1'b0, '0, 1'b0, 1'b1);
    check("uflow_err",  32'(pop_err), 1);
    check("uflow_fill", 32'(fill_level), 0);
    step(1'b1, 13'h0123, 1'b0, 1'b0);
    check("uflow_push_fill", 32'(fill_level), 1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("uflow_sticky", 32'(pop_err), 1);

    // Lookahead: 0x0408 and 0x040F share bank 1 / row 1, 0x0808 is bank 2
`ifdef DRAM_REQ_LOOKAHEAD_EN
    exp_hit = 1'b1;
`else
    exp_hit = 1'b0;
`endif
    step(1'b1, 13'h0408, 1'b0, 1'b0);
    check("la_single_hit", 32'(next_row_hit), 0);
    step(1'b1, 13'h040F, 1'b1, 1'b0);
    step(1'b1, 13'h0808, 1'b0, 1'b0);
    check("la_hit", 32'(next_row_hit), 32'(exp_hit));
    step(1'b0, '0, 1'b0, 1'b1);
    check("la_miss", 32'(next_row_hit), 0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Mid-stream async reset with 3 entries
    step(1'b1, 13'h1111, 1'b1, 1'b0);
    step(1'b1, 13'h0222, 1'b0, 1'b0);
    step(1'b1, 13'h0333, 1'b1, 1'b0);
    check("pre_rst_fill", 32'(fill_level), 3);
    #2 rst_b = 1'b0;
    #1;
    check("mid_rst_val",  32'(addr_val), 0);
    check("mid_rst_fill", 32'(fill_level), 0);
    check("mid_rst_err",  32'(pop_err), 0);
    check("mid_rst_bank", 32'(bank_id), 0);
    sb.delete();
    mcount = 0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(host_ready), 1);
    step(1'b1, 13'h1A5B, 1'b0, 1'b0);
    check("post_rst_fill", 32'(fill_level), 1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("sb_empty", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dram_req_queue.md
Name: dram_req_queue

Overview:
- Front-end request buffer that sits directly upstream of the DRAM controller FSM.
- Accepts host requests (flat address plus write flag) over a valid/ready handshake and stores them in a FIFO.
- Splits the head entry into bank/row/col fields and presents it to the FSM as addr_val / bank_id / row_id / col_id.
- Holds the head entry until the FSM reports the column access complete (col_done, wired from the FSM's col_en).

Parameters:
- NUMBER_OF_BANKS, 8, number of banks; BANK_W = $clog2(NUMBER_OF_BANKS).
- NUMBER_OF_ROWS, 128, rows per bank; ROW_W = $clog2(NUMBER_OF_ROWS).
- NUMBER_OF_COLS, 8, columns per row; COL_W = $clog2(NUMBER_OF_COLS).
- FIFO_DEPTH, 4, request entries; power of two, at least 2.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_b  in  1  asynchronous active-low reset.
- host_valid  in  1  host request valid.
- host_ready  out  1  queue can accept a request.
- host_addr  in  ADDR_W (= BANK_W+ROW_W+COL_W, 13 by default)  flat address.
- host_we  in  1  1 = write, 0 = read.
- col_done  in  1  FSM column access done; pops the head entry.
- addr_val  out  1  head entry valid.
- bank_id  out  BANK_W  head bank.
- row_id  out  ROW_W  head row.
- col_id  out  COL_W  head column.
- req_we  out  1  head write flag.
- fill_level  out  $clog2(FIFO_DEPTH+1)  number of stored entries.
- next_row_hit  out  1  lookahead flag (see Optional Feature).
- pop_err  out  1  sticky flag: col_done seen while empty.

Behaviour:
- Address split: col = host_addr[COL_W-1:0]; row = host_addr[COL_W+ROW_W-1:COL_W]; bank = host_addr[ADDR_W-1:COL_W+ROW_W].
- The split is done at push time; split fields are stored per entry.
- Storage: array of FIFO_DEPTH entries {bank,row,col,we}; wr_ptr and rd_ptr are $clog2(FIFO_DEPTH) bits and wrap naturally; count is kept separately.
- host_ready = (count != FIFO_DEPTH). It depends only on state, with no combinational path from col_done.
- push = host_valid & host_ready. Writes the entry at wr_ptr; wr_ptr+1.
- pop = col_done & (count != 0). rd_ptr+1.
- Push and pop in the same cycle: both take effect, count unchanged.
- Full plus col_done: pop only. host_ready rises the next cycle, so there is no same-cycle bypass.
- Empty plus push: entry visible on outputs the next cycle (latency 1); no flow-through.
- Head outputs = entry[rd_ptr] (registered storage, mux read).
- addr_val = (count != 0).
- Head fields are held stable while addr_val is 1 and no pop occurs.
- col_done while empty: no pointer change; pop_err set to 1 and held until reset.
- fill_level = count.
- Reset (async, rst_b low, also mid-operation):
  - pointers and count cleared to 0; all storage entries cleared to 0.
  - addr_val, bank_id, row_id, col_id, req_we, pop_err, next_row_hit = 0.
  - host_ready = 1 one cycle after release.
  - In-flight requests are discarded.
- No state machine beyond FIFO occupancy: empty (count 0), partial, full (count FIFO_DEPTH).
  - empty -> partial on push.
  - partial -> full on push without pop at count FIFO_DEPTH-1.
  - full -> partial on pop.
  - partial -> empty on pop without push at count 1.

Optional Feature:
- Macro DRAM_REQ_LOOKAHEAD_EN.
- Defined: next_row_hit = (count >= 2) & (entry[rd_ptr+1].bank == bank_id) & (entry[rd_ptr+1].row == row_id). Combinational from registered state. Lets the FSM skip precharge on a same-row follow-up.
- Undefined: next_row_hit tied to 0; no comparator logic is generated. The port is always present.

Decomposition:
- Package dram_ctrl_pkg holds:
  - default BANK/ROW/COL counts and derived widths.
  - address field offsets (COL_LSB=0, ROW_LSB=COL_W, BANK_LSB=COL_W+ROW_W).
  - request entry struct/typedef.
  - FSM cmd encodings (ACT=2'b00, RDWR=2'b01, REF=2'b10, PRE=2'b11).
- One sub-module is natural: dram_req_fifo, a generic synchronous FIFO with count, full/empty and a head+1 peek port. dram_req_queue wraps it with the address split and flags.

Test Plan:
- Reset: assert rst_b=0 mid-stream with 3 entries -> addr_val=0, fill_level=0, pop_err=0 immediately; host_ready=1 after release.
- Single request: host_addr=13'h1A5B, we=1, one cycle -> next cycle addr_val=1, bank_id=6, row_id=75, col_id=3, req_we=1. col_done=1 -> addr_val=0 the following cycle.
- Fill: 4 back-to-back pushes with no col_done -> fill_level=4, host_ready=0. A 5th host_valid is held and not accepted. One col_done -> host_ready=1 the next cycle, then the 5th is accepted.
- Simultaneous push and pop at fill_level=2 -> fill_level stays 2; head advances to the 2nd entry; order preserved across pointer wrap after 10 total requests.
- Underflow: col_done=1 while empty -> pointers unchanged, pop_err=1 and stays 1 after later valid traffic.
- Lookahead (macro defined): push addr 13'h0408 then 13'h040F (same bank 1/row 1) -> next_row_hit=1; then push 13'h0808 behind them -> after one pop next_row_hit=0. With macro undefined -> next_row_hit always 0.
